// File: rtl/relu_requant.sv
// ---------------------------------------------------------------------------
// relu_requant
//
// Requantization stage that sits behind the channel accumulator. Each
// accepted 32-bit accumulator result optionally goes through ReLU. It is then
// divided by 2^shift with round-half-up and clamped to a signed 8-bit
// activation. Results sit in a small FIFO, so a stalled consumer never loses
// an element that was already accepted. A sticky counter reports how many
// results had to be clamped.
//
// Ports:
//    clk_i          clock, all state on the rising edge
//    rst_ni         asynchronous active-low reset
//    in_valid_i     input element valid
//    in_data_i      signed accumulator result
//    in_ready_o     block can take an element this cycle
//    shift_i        right-shift amount, captured with the element
//    relu_en_i      clamp negatives to zero, captured with the element
//    out_valid_o    FIFO head valid
//    out_data_o     signed activation at FIFO head (zero when empty)
//    out_ready_i    consumer takes the head this cycle
//    fifo_count_o   current FIFO occupancy
//    sat_count_o    saturated-result counter, sticks at 16'hFFFF
// ---------------------------------------------------------------------------
module relu_requant #(
   parameter int IN_RESOLUTION  = 32,
   parameter int OUT_RESOLUTION = 8,
   parameter int SHIFT_WIDTH    = 5,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          in_valid_i,
   input  logic [IN_RESOLUTION-1:0]      in_data_i,
   output logic                          in_ready_o,
   input  logic [SHIFT_WIDTH-1:0]        shift_i,
   input  logic                          relu_en_i,
   output logic                          out_valid_o,
   output logic [OUT_RESOLUTION-1:0]     out_data_o,
   input  logic                          out_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic [15:0]                   sat_count_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int EXT_W = IN_RESOLUTION + 1;

   localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'((2 ** (OUT_RESOLUTION - 1)) - 1);
   localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(-(2 ** (OUT_RESOLUTION - 1)));

   logic                     accept;
   logic signed [EXT_W-1:0]  reluValue;
   logic signed [EXT_W-1:0]  roundBias;
   logic signed [EXT_W-1:0]  roundSum;
   logic signed [EXT_W-1:0]  shiftedValue;

   logic                     s1Valid_q, s1Valid_d;
   logic signed [EXT_W-1:0]  s1Value_q, s1Value_d;

   logic [OUT_RESOLUTION-1:0] satData;
   logic                      satFlag;

   logic [OUT_RESOLUTION-1:0] fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]          wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]          rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic [15:0]               satCount_q, satCount_d;
   logic                      push;
   logic                      pop;

   // Stage-1 arithmetic on the incoming element. The value is widened by one
   // bit so that adding the rounding bias to the largest positive input
   // cannot wrap. Shifts wider than the extended value give an exact zero
   // after rounding, and the bias would not fit in the word anyway, so they
   // are short-circuited.
   always_comb begin
      reluValue = {in_data_i[IN_RESOLUTION-1], in_data_i};
      if (relu_en_i && in_data_i[IN_RESOLUTION-1]) begin
         reluValue = '0;
      end
      roundBias    = '0;
      roundSum     = reluValue;
      shiftedValue = reluValue;
      if (shift_i != '0) begin
         if (int'(shift_i) > IN_RESOLUTION) begin
            shiftedValue = '0;
         end else begin
            roundBias    = EXT_W'(1) << (shift_i - SHIFT_WIDTH'(1));
            roundSum     = reluValue + roundBias;
            shiftedValue = roundSum >>> shift_i;
         end
      end
   end

   // The stage-1 register holds at most one element. It always has a FIFO
   // slot waiting for it, so it drains every cycle and its valid bit simply
   // follows whether something was accepted on this edge.
   always_comb begin
      accept    = in_valid_i && in_ready_o;
      s1Valid_d = accept;
      s1Value_d = accept ? shiftedValue : s1Value_q;
   end

   // Stage-1 register. Reset discards any element that is in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1Valid_q <= 1'b0;
         s1Value_q <= '0;
      end else begin
         s1Valid_q <= s1Valid_d;
         s1Value_q <= s1Value_d;
      end
   end

   // Stage-2 saturation to the activation range. In-range values pass their
   // low bits through unchanged. Out-of-range values clamp to the nearest
   // limit and raise the saturation flag.
   always_comb begin
      satData = s1Value_q[OUT_RESOLUTION-1:0];
      satFlag = 1'b0;
      if (s1Value_q > SAT_HI) begin
         satData = SAT_HI[OUT_RESOLUTION-1:0];
         satFlag = 1'b1;
      end else if (s1Value_q < SAT_LO) begin
         satData = SAT_LO[OUT_RESOLUTION-1:0];
         satFlag = 1'b1;
      end
   end

   // FIFO bookkeeping. Pushes come only from stage 1, and pops follow the
   // output handshake. The power-of-two depth lets the pointers wrap on
   // their own. The saturation counter stops at all-ones instead of wrapping.
   always_comb begin
      push    = s1Valid_q;
      pop     = out_valid_o && out_ready_i;
      wrPtr_d = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
      rdPtr_d = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
         count_d = count_q - CNT_W'(1);
      end
      satCount_d = satCount_q;
      if (push && satFlag && (satCount_q != 16'hFFFF)) begin
         satCount_d = satCount_q + 16'd1;
      end
   end

   // FIFO control registers and the saturation counter. Reset empties the
   // buffer and clears the counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         satCount_q <= '0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         satCount_q <= satCount_d;
      end
   end

   // FIFO storage. It needs no reset because the data output is masked
   // whenever the buffer is empty.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifoMem[wrPtr_q] <= satData;
      end
   end

   // Outputs come only from registered state. Ready counts the element in
   // stage 1 as already occupying a slot, so a stage-1 element never has to
   // wait.
   always_comb begin
      in_ready_o   = (count_q + CNT_W'(s1Valid_q)) < CNT_W'(FIFO_DEPTH);
      out_valid_o  = (count_q != '0);
      out_data_o   = out_valid_o ? fifoMem[rdPtr_q] : '0;
      fifo_count_o = count_q;
      sat_count_o  = satCount_q;
   end

endmodule

// File: tb/tb_relu_requant.sv
// ---------------------------------------------------------------------------
// tb_relu_requant
//
// Self-checking bench for relu_requant. A reference model keeps the expected
// FIFO contents as a queue of activations. Each value is computed with
// ordinary integer arithmetic from the element's ReLU and shift settings.
// A compare process checks the DUT against that model on every falling edge.
// Directed sequences with hand-computed results pin down rounding,
// saturation, backpressure, streaming and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_relu_requant;

   logic        clk_i;
   logic        rst_ni;
   logic        in_valid_i;
   logic [31:0] in_data_i;
   logic        in_ready_o;
   logic [4:0]  shift_i;
   logic        relu_en_i;
   logic        out_valid_o;
   logic [7:0]  out_data_o;
   logic        out_ready_i;
   logic [2:0]  fifo_count_o;
   logic [15:0] sat_count_o;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] fifoModel [$];
   logic [7:0] popLog [$];
   bit         pendValid = 0;
   logic [7:0] pendData  = '0;
   bit         pendSat   = 0;
   int         satModel  = 0;

   relu_requant dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .in_valid_i   (in_valid_i),
      .in_data_i    (in_data_i),
      .in_ready_o   (in_ready_o),
      .shift_i      (shift_i),
      .relu_en_i    (relu_en_i),
      .out_valid_o  (out_valid_o),
      .out_data_o   (out_data_o),
      .out_ready_i  (out_ready_i),
      .fifo_count_o (fifo_count_o),
      .sat_count_o  (sat_count_o)
   );

   // Free-running clock with a 10-time-unit period.
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Each comparison goes through this one task so the counters stay
   // consistent.
   task automatic checkOutput(input string name, input longint actual, input longint expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference arithmetic: optional ReLU, divide by 2^shift rounding half
   // upward (a floor of x/2^s + 1/2), then clamp to the int8 range.
   function automatic void modelCalc(input bit relu, input int sh, input logic [31:0] din,
                                     output logic [7:0] q, output bit sat);
      longint x;
      longint r;
      x = longint'($signed(din));
      if (relu && x < 0) x = 0;
      if (sh == 0) r = x;
      else         r = (x + (longint'(1) << (sh - 1))) >>> sh;
      sat = 0;
      if (r > 127) begin
         q = 8'h7F;
         sat = 1;
      end else if (r < -128) begin
         q = 8'h80;
         sat = 1;
      end else begin
         q = r[7:0];
      end
   endfunction

   // Model bookkeeping on each rising edge. An accepted element spends one
   // cycle in the pipeline slot before it joins the output queue. The model
   // decides readiness from its own occupancy, not from the DUT.
   always @(posedge clk_i) begin : modelUpdate
      bit         modelReady;
      logic [7:0] q;
      bit         s;
      if (!rst_ni) begin
         fifoModel.delete();
         pendValid = 0;
         satModel  = 0;
      end else begin
         modelReady = (fifoModel.size() + int'(pendValid)) < 4;
         if (fifoModel.size() > 0 && out_ready_i) begin
            void'(fifoModel.pop_front());
         end
         if (pendValid) begin
            fifoModel.push_back(pendData);
            if (pendSat && satModel < 65535) satModel++;
         end
         pendValid = 0;
         if (in_valid_i && modelReady) begin
            modelCalc(relu_en_i, int'(shift_i), in_data_i, q, s);
            pendValid = 1;
            pendData  = q;
            pendSat   = s;
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         checkOutput("model_out_valid", longint'(out_valid_o), longint'(fifoModel.size() != 0));
         checkOutput("model_fifo_count", longint'(fifo_count_o), longint'(fifoModel.size()));
         checkOutput("model_out_data", longint'(out_data_o),
                     (fifoModel.size() != 0) ? longint'(fifoModel[0]) : 64'd0);
         checkOutput("model_in_ready", longint'(in_ready_o),
                     longint'((fifoModel.size() + int'(pendValid)) < 4));
         checkOutput("model_sat_count", longint'(sat_count_o), longint'(satModel));
      end
   end

   // Log of every value the consumer actually takes, in order.
   always @(negedge clk_i) begin
      if (rst_ni && out_valid_o && out_ready_i) popLog.push_back(out_data_o);
   end

   // Offer one element and hold it until it is taken, within a bounded wait.
   // Afterwards the data and control inputs carry junk, which the DUT must
   // ignore while valid is low.
   task automatic applyStimulus(input bit relu, input logic [4:0] sh, input logic [31:0] din);
      int tries = 0;
      bit done  = 0;
      in_valid_i = 1'b1;
      relu_en_i  = relu;
      shift_i    = sh;
      in_data_i  = din;
      while (!done && tries < 50) begin
         @(negedge clk_i);
         done = in_ready_o;
         @(posedge clk_i);
         #1;
         tries++;
      end
      in_valid_i = 1'b0;
      relu_en_i  = 1'b1;
      shift_i    = 5'h1F;
      in_data_i  = 32'hDEAD_BEEF;
      checkOutput("accept_within_bound", longint'(done), 1);
   endtask

   // Send one element into an empty, freely draining FIFO and check the head
   // value and saturation count one edge after acceptance.
   task automatic sendAndCheck(input string name, input bit relu, input logic [4:0] sh,
                               input logic [31:0] din, input logic [7:0] expData, input int expSat);
      applyStimulus(relu, sh, din);
      @(posedge clk_i);
      #1;
      checkOutput({name, "_data"}, longint'(out_data_o), longint'(expData));
      checkOutput({name, "_sat"}, longint'(sat_count_o), longint'(expSat));
   endtask

   // Watchdog so that a stuck handshake can never hang the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      int  idx;
      int  maxCnt;
      bit  dropped;
      bit  acc;
      bit  readyBack;
      int  waitCycles;

      in_valid_i  = 1'b0;
      in_data_i   = '0;
      shift_i     = '0;
      relu_en_i   = 1'b0;
      out_ready_i = 1'b1;
      rst_ni      = 1'b0;

      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      $display("[TB] checking reset state");
      checkOutput("reset_in_ready", longint'(in_ready_o), 1);
      checkOutput("reset_out_valid", longint'(out_valid_o), 0);
      checkOutput("reset_out_data", longint'(out_data_o), 0);
      checkOutput("reset_fifo_count", longint'(fifo_count_o), 0);
      checkOutput("reset_sat_count", longint'(sat_count_o), 0);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // 4736 / 256 = 18.5, which rounds up to 19. Valid is expected in the
      // second cycle after the accept edge.
      $display("[TB] rounding with ReLU and latency");
      applyStimulus(1'b1, 5'd8, 32'd4736);
      checkOutput("latency_not_yet_valid", longint'(out_valid_o), 0);
      @(posedge clk_i);
      #1;
      checkOutput("latency_valid", longint'(out_valid_o), 1);
      checkOutput("round_relu_data", longint'(out_data_o), 8'h13);
      checkOutput("round_relu_sat", longint'(sat_count_o), 0);

      $display("[TB] negative paths");
      sendAndCheck("relu_neg", 1'b1, 5'd2, 32'hFFFF_FED4, 8'h00, 0);
      sendAndCheck("neg_shift2", 1'b0, 5'd2, 32'hFFFF_FED4, 8'hB5, 0);
      sendAndCheck("neg_half", 1'b0, 5'd1, 32'hFFFF_FFFD, 8'hFF, 0);

      $display("[TB] saturation");
      sendAndCheck("sat_pos", 1'b0, 5'd0, 32'h7FFF_FFFF, 8'h7F, 1);
      sendAndCheck("sat_neg", 1'b0, 5'd0, 32'h8000_0000, 8'h80, 2);
      sendAndCheck("sat_round_nowrap", 1'b0, 5'd1, 32'h7FFF_FFFF, 8'h7F, 3);

      $display("[TB] maximum shift");
      sendAndCheck("shift31_small_neg", 1'b0, 5'd31, 32'hFFFF_FFFB, 8'h00, 3);
      sendAndCheck("shift31_min", 1'b0, 5'd31, 32'h8000_0000, 8'hFF, 3);
      sendAndCheck("shift31_max", 1'b0, 5'd31, 32'h7FFF_FFFF, 8'h01, 3);

      // Backpressure: four elements fill the buffer, the next two must wait.
      $display("[TB] backpressure");
      @(posedge clk_i);
      #1;
      @(posedge clk_i);
      #1;
      popLog.delete();
      out_ready_i = 1'b0;
      relu_en_i   = 1'b0;
      shift_i     = 5'd0;
      in_valid_i  = 1'b1;
      idx = 1;
      for (int c = 0; c < 8; c++) begin
         in_data_i = 32'(idx);
         @(negedge clk_i);
         acc = in_ready_o;
         @(posedge clk_i);
         #1;
         if (acc) idx++;
      end
      checkOutput("bp_accepted", longint'(idx - 1), 4);
      checkOutput("bp_in_ready_low", longint'(in_ready_o), 0);
      checkOutput("bp_fifo_full", longint'(fifo_count_o), 4);
      checkOutput("bp_head", longint'(out_data_o), 1);
      out_ready_i = 1'b1;
      readyBack   = 0;
      for (int c = 0; c < 20; c++) begin
         if (idx > 6) break;
         in_data_i = 32'(idx);
         @(negedge clk_i);
         acc = in_ready_o;
         if (in_ready_o) readyBack = 1;
         @(posedge clk_i);
         #1;
         if (acc) idx++;
      end
      in_valid_i = 1'b0;
      checkOutput("bp_ready_returns", longint'(readyBack), 1);
      checkOutput("bp_all_accepted", longint'(idx - 1), 6);
      waitCycles = 0;
      while (out_valid_o && waitCycles < 20) begin
         @(posedge clk_i);
         #1;
         waitCycles++;
      end
      checkOutput("bp_drained", longint'(out_valid_o), 0);
      checkOutput("bp_pop_count", longint'(popLog.size()), 6);
      for (int k = 0; k < 6; k++) begin
         if (k < popLog.size()) checkOutput("bp_order", longint'(popLog[k]), longint'(k + 1));
      end

      // Streaming with back-to-back elements and a free-running consumer.
      $display("[TB] streaming");
      popLog.delete();
      dropped = 0;
      maxCnt  = 0;
      in_valid_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_data_i = 32'(i * 700 - 5000);
         relu_en_i = i[0];
         shift_i   = 5'(i % 5);
         @(negedge clk_i);
         if (!in_ready_o) dropped = 1;
         if (int'(fifo_count_o) > maxCnt) maxCnt = int'(fifo_count_o);
         @(posedge clk_i);
         #1;
      end
      in_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      @(posedge clk_i);
      #1;
      checkOutput("stream_ready_held", longint'(dropped), 0);
      checkOutput("stream_count_le2", longint'(maxCnt <= 2), 1);
      checkOutput("stream_one_per_cycle", longint'(popLog.size()), 16);

      // Reset while three entries are buffered.
      $display("[TB] reset mid-stream");
      out_ready_i = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'h7FFF_FFFF);
      applyStimulus(1'b0, 5'd0, 32'd40);
      applyStimulus(1'b0, 5'd0, 32'hFFFF_FFFB);
      @(posedge clk_i);
      #1;
      checkOutput("pre_reset_count", longint'(fifo_count_o), 3);
      checkOutput("pre_reset_head", longint'(out_data_o), 8'h7F);
      #3;
      rst_ni = 1'b0;
      #1;
      checkOutput("async_reset_valid", longint'(out_valid_o), 0);
      checkOutput("async_reset_count", longint'(fifo_count_o), 0);
      checkOutput("async_reset_sat", longint'(sat_count_o), 0);
      checkOutput("async_reset_data", longint'(out_data_o), 0);
      checkOutput("async_reset_ready", longint'(in_ready_o), 1);
      @(posedge clk_i);
      #1;
      rst_ni      = 1'b1;
      out_ready_i = 1'b1;
      popLog.delete();
      repeat (3) begin
         @(posedge clk_i);
         #1;
      end
      checkOutput("post_reset_no_stale", longint'(popLog.size()), 0);
      sendAndCheck("post_reset_first", 1'b0, 5'd3, 32'd100, 8'd13, 0);
      @(posedge clk_i);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/relu_requant.md
Name: relu_requant

Overview:
- Stage directly downstream of the channel accumulator. It consumes signed 32-bit accumulated-plus-bias results over a valid/ready handshake.
- Per element it applies optional ReLU, a rounding arithmetic right shift and saturation to 8-bit signed. The result is the next layer's activation.
- Results are buffered in a small FIFO so downstream backpressure never drops an accepted element. A sticky counter records how many outputs saturated.

Parameters:
- IN_RESOLUTION, 32, input accumulator width (signed, two's complement)
- OUT_RESOLUTION, 8, output activation width (signed)
- SHIFT_WIDTH, 5, width of the requantization shift amount
- FIFO_DEPTH, 4, output buffer entries (power of two, >= 2)

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- in_valid_i  input  1  input element valid
- in_data_i  input  IN_RESOLUTION  signed accumulator result
- in_ready_o  output  1  block can accept an element this cycle
- shift_i  input  SHIFT_WIDTH  right-shift amount, sampled with each accepted element
- relu_en_i  input  1  1 = clamp negatives to 0, sampled with each accepted element
- out_valid_o  output  1  FIFO head valid
- out_data_o  output  OUT_RESOLUTION  signed activation at FIFO head
- out_ready_i  input  1  downstream accepts head this cycle
- fifo_count_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- sat_count_o  output  16  number of saturated results, sticky at 16'hFFFF

Behaviour:
- Reset (async assert, sync release): s1_valid=0, FIFO empty, in_ready_o=1, out_valid_o=0, out_data_o=0, fifo_count_o=0, sat_count_o=0. Asserting reset mid-operation discards in-flight and buffered data.
- Accept: the element transfers on a rising edge where in_valid_i && in_ready_o. shift_i and relu_en_i are captured in the same transfer.
- Stage 1 (registered at accept):
  - x = in_data_i, set to 0 if relu_en_i and x < 0.
  - x is sign-extended to IN_RESOLUTION+1 bits.
  - If shift > 0: r = (x + 2^(shift-1)) >>> shift, i.e. round half toward +inf.
  - If shift = 0: r = x.
  - The extra bit guarantees no overflow on the rounding add.
- Stage 2 (combinational from s1, written into FIFO on the next edge):
  - r > 2^(OUT-1)-1 gives 127 with sat flag set.
  - r < -2^(OUT-1) gives -128 with sat flag set.
  - Otherwise the low OUT_RESOLUTION bits of r, sat flag clear.
- Latency: element accepted at edge N is in the FIFO at edge N+1. With the FIFO previously empty, out_valid_o is high in the cycle after edge N+1.
- Flow control:
  - in_ready_o = (fifo_count + s1_valid) < FIFO_DEPTH, from registered state only, with no combinational path from out_ready_i.
  - An s1 entry therefore always has a free FIFO slot and never stalls.
- FIFO:
  - out_valid_o = (count != 0); out_data_o = head entry, and is 0 when empty.
  - Pop on out_valid_o && out_ready_i.
  - Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; order is strictly preserved.
- sat_count_o increments by 1 per FIFO write with sat flag set and saturates at 16'hFFFF, with no wrap. It is cleared only by reset.
- Throughput: 1 element/cycle while out_ready_i is held high. Occupancy stays <= 2, so in_ready_o stays 1.
- A shift of >= IN_RESOLUTION is legal: the result is 0 or -1 before rounding, then rounded.
- shift_i and relu_en_i are ignored when no transfer occurs.

Test Plan:
- Rounding with ReLU: relu=1, shift=8, in=4736 -> out_data 0x13 (18.5 rounds to 19), sat_count 0, out_valid 2 cycles after accept.
- Negative paths:
  - relu=1, shift=2, in=-300 -> 0x00.
  - relu=0, shift=2, in=-300 -> 0xB5 (-75).
  - relu=0, shift=1, in=-3 -> 0xFF (-1.5 rounds to -1).
- Saturation:
  - relu=0, shift=0, in=0x7FFFFFFF -> 0x7F, sat_count=1.
  - in=0x80000000 -> 0x80, sat_count=2.
  - shift=1, in=0x7FFFFFFF -> 0x7F, with no wrap in the rounding add, sat_count=3.
- Backpressure: out_ready=0, offer 6 consecutive elements 1..6 with shift=0 -> exactly 4 accepted and in_ready_o=0 after the 4th. Then raise out_ready -> outputs 1,2,3,4 in order, in_ready returns to 1, then 5,6 are accepted.
- Streaming: out_ready=1, 16 back-to-back elements -> one output per cycle, in_ready never drops, fifo_count_o <= 2, order preserved.
- Reset mid-stream: assert rst_ni low with 3 entries buffered -> out_valid_o, fifo_count_o and sat_count_o are 0 immediately, no stale data is output after release, and the first post-reset element emerges correctly.
